// File: rtl/fnn_wmem_pkg.sv
// Shared types and helpers for the per-neuron loadable weight store.
// Optional build macro: WMEM_PARITY_EN (adds one even-parity bit per word).
package fnn_wmem_pkg;

    // Default weight word width (signed fixed point, opaque to the store).
    localparam int WMEM_DATA_WIDTH = 16;

    // Widest word the parity helper covers.
    localparam int WMEM_MAX_WIDTH = 64;

    // Stream controller states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } wmem_state_t;

    // Even parity: XOR of all bits. Callers zero-extend narrower words,
    // which leaves the result unchanged.
    function automatic logic even_parity(input logic [WMEM_MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/wmem_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with
// read enable. The read register is the streamed output register, so it
// resets to zero while the storage array itself is never cleared.
// Optional build macro: WMEM_PARITY_EN (widens WIDTH at the instantiation).
module wmem_sdp_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 30,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; holds its value whenever re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/weight_stream_mem.sv
// Loadable weight store for one neuron: words are written through a load
// port while idle and streamed out mem[0..NUM_WEIGHT-1] under a valid/ready
// handshake with back-pressure and a last-beat flag.
// Optional build macro: WMEM_PARITY_EN (per-word even parity, par_err flag).
//
// Handshake: a beat transfers on a rising edge where w_valid && w_ready.
// While w_valid && !w_ready, w_data/w_last/par_err are held unchanged.
// w_valid never drops without a transfer.
module weight_stream_mem
    import fnn_wmem_pkg::*;
#(
    parameter int NUM_WEIGHT = 30,
    parameter int DATA_WIDTH = WMEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_en,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_err,
    input  logic                  start,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_last,
    output logic                  par_err
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_STREAM = STREAM;
    localparam logic [1:0] ST_DRAIN  = DRAIN;

`ifdef WMEM_PARITY_EN
    localparam int RAM_W = DATA_WIDTH + 1;
`else
    localparam int RAM_W = DATA_WIDTH;
`endif

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  in_range;
    logic                  ld_ok;
    logic                  re;
    logic                  at_last;
    logic [RAM_W-1:0]      ram_wdata;
    logic [RAM_W-1:0]      ram_rdata;

    // Writes are only safe while no stream is reading the array.
    assign in_range = 32'(ld_addr) < 32'(NUM_WEIGHT);
    assign ld_ok    = ld_en && (state == ST_IDLE) && in_range;

    // Fetch the next word whenever the output register is empty or draining.
    assign re      = (state == ST_STREAM) && (!w_valid || w_ready);
    assign at_last = (rd_addr == ADDR_WIDTH'(NUM_WEIGHT - 1));
    assign busy    = (state != ST_IDLE);

`ifdef WMEM_PARITY_EN
    // Store parity alongside the word; the output register then carries it,
    // so par_err travels with (and holds with) its beat.
    assign ram_wdata = {even_parity(64'(ld_data)), ld_data};
    assign w_data    = ram_rdata[DATA_WIDTH-1:0];
    assign par_err   = even_parity(64'(ram_rdata));
`else
    assign ram_wdata = ld_data;
    assign w_data    = ram_rdata;
    assign par_err   = 1'b0;
`endif

    wmem_sdp_ram #(
        .WIDTH (RAM_W),
        .DEPTH (NUM_WEIGHT),
        .AW    (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ld_ok),
        .waddr (ld_addr),
        .wdata (ram_wdata),
        .re    (re),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Stream controller: state, read address, valid and last flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rd_addr <= '0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (re) begin
                        w_valid <= 1'b1;
                        w_last  <= at_last;
                        if (at_last) begin
                            rd_addr <= '0;
                            state   <= ST_DRAIN;
                        end else begin
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_valid && w_ready && w_last) begin
                        w_valid <= 1'b0;
                        w_last  <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Flag a rejected load for exactly the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ld_err <= 1'b0;
        else        ld_err <= ld_en && !ld_ok;
    end

endmodule

// File: tb/tb_weight_stream_mem.sv
// Directed bench for weight_stream_mem (default build, or with
// WMEM_PARITY_EN defined to exercise the parity path).
module tb_weight_stream_mem;

    localparam int NW = 30;
    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_err;
    logic          start;
    logic          busy;
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;
    logic          par_err;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q[$];
    int            par_bad_idx = -1;

    weight_stream_mem #(
        .NUM_WEIGHT (NW),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ld_err  (ld_err),
        .start   (start),
        .busy    (busy),
        .w_data  (w_data),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_last  (w_last),
        .par_err (par_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance one edge and sample 1 ns after it.
    task tick;
        @(posedge clk);
        #1;
    endtask

    task load_word(input int a, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a[AW-1:0];
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task load_ramp;
        for (int i = 0; i < NW; i++) load_word(i, DW'(16'h0100 + i));
    endtask

    task fill_ramp_q;
        exp_q.delete();
        for (int i = 0; i < NW; i++) exp_q.push_back(DW'(16'h0100 + i));
    endtask

    task start_stream;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Consume the current stream with a rotating ready pattern, checking
    // order, last flag, parity flag and stability while stalled.
    task drain_check(input logic [3:0] pat, input string name);
        int            beat;
        bit            done;
        logic          stall;
        logic [DW-1:0] held;
        logic [DW-1:0] e;
        beat = 0;
        done = 0;
        for (int k = 0; k < 400 && !done; k++) begin
            w_ready = pat[k % 4];
            if (w_valid && w_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_beat: got %h, required none", name, w_data);
                end else begin
                    e = exp_q.pop_front();
                    if (w_data !== e) begin
                        bad++;
                        $display("FAIL %s data beat %0d: got %h, required %h", name, beat, w_data, e);
                    end
                    total++;
                    if (w_last !== (exp_q.size() == 0)) begin
                        bad++;
                        $display("FAIL %s last beat %0d: got %b, required %b", name, beat, w_last, exp_q.size() == 0);
                    end
                end
                total++;
                if (par_err !== (beat == par_bad_idx)) begin
                    bad++;
                    $display("FAIL %s par_err beat %0d: got %b, required %b", name, beat, par_err, beat == par_bad_idx);
                end
                beat++;
            end
            stall = w_valid && !w_ready;
            held  = w_data;
            tick();
            if (stall) begin
                total++;
                if (w_valid !== 1'b1 || w_data !== held) begin
                    bad++;
                    $display("FAIL %s stall_hold: got v=%b d=%h, required v=1 d=%h", name, w_valid, w_data, held);
                end
            end
            if (!busy && !w_valid) done = 1;
        end
        w_ready = 1'b1;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: stream still busy after 400 cycles, required idle", name);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing_beats: got %0d left, required 0", name, exp_q.size());
        end
    endtask

    task test_reset;
        rst_n   = 1'b0;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        start   = 1'b0;
        w_ready = 1'b1;
        #12;
        total++;
        if (w_data !== '0 || w_valid !== 1'b0 || w_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_stream: got d=%h v=%b l=%b, required 0 0 0", w_data, w_valid, w_last);
        end
        total++;
        if (busy !== 1'b0 || ld_err !== 1'b0 || par_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got busy=%b ld_err=%b par_err=%b, required 0 0 0", busy, ld_err, par_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task test_stream_basic;
        load_ramp();
        total++;
        if (ld_err !== 1'b0) begin
            bad++;
            $display("FAIL basic_load_ok: got ld_err=%b, required 0", ld_err);
        end
        w_ready = 1'b1;
        start_stream();
        total++;
        if (busy !== 1'b1 || w_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_latency1: got busy=%b v=%b, required 1 0", busy, w_valid);
        end
        tick();
        for (int i = 0; i < NW; i++) begin
            total++;
            if (w_valid !== 1'b1 || w_data !== DW'(16'h0100 + i) || w_last !== (i == NW - 1)
                || par_err !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_beat %0d: got v=%b d=%h l=%b p=%b busy=%b, required 1 %h %b 0 1",
                         i, w_valid, w_data, w_last, par_err, busy, DW'(16'h0100 + i), i == NW - 1);
            end
            tick();
        end
        total++;
        if (busy !== 1'b0 || w_valid !== 1'b0 || w_last !== 1'b0) begin
            bad++;
            $display("FAIL basic_end: got busy=%b v=%b l=%b, required 0 0 0", busy, w_valid, w_last);
        end
    endtask

    task test_ready_toggle;
        fill_ramp_q();
        start_stream();
        drain_check(4'b1001, "toggle");
    endtask

    task test_load_errors;
        w_ready = 1'b0;
        start_stream();
        ld_en   = 1'b1;
        ld_addr = 5'd5;
        ld_data = 16'hDEAD;
        start   = 1'b1;
        tick();
        ld_en = 1'b0;
        start = 1'b0;
        total++;
        if (ld_err !== 1'b1) begin
            bad++;
            $display("FAIL ld_err_busy: got %b, required 1", ld_err);
        end
        tick();
        total++;
        if (ld_err !== 1'b0) begin
            bad++;
            $display("FAIL ld_err_pulse_busy: got %b, required 0", ld_err);
        end
        fill_ramp_q();
        drain_check(4'b1111, "busy_load");
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || w_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_extra_stream: got busy=%b v=%b, required 0 0", busy, w_valid);
        end
        load_word(30, 16'hBAD0);
        total++;
        if (ld_err !== 1'b1) begin
            bad++;
            $display("FAIL ld_err_range: got %b, required 1", ld_err);
        end
        tick();
        total++;
        if (ld_err !== 1'b0) begin
            bad++;
            $display("FAIL ld_err_pulse_range: got %b, required 0", ld_err);
        end
        fill_ramp_q();
        start_stream();
        drain_check(4'b1111, "mem5_intact");
    endtask

    task test_start_in_drain;
        int  n;
        w_ready = 1'b1;
        start_stream();
        n = 0;
        while (!(w_valid && w_last) && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL drain_wait: got no last beat, required one within 100 cycles");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || w_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_start_ignored: got busy=%b v=%b, required 0 0", busy, w_valid);
        end
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || w_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_start_late: got busy=%b v=%b, required 0 0", busy, w_valid);
        end
    endtask

    task test_ld_start_same;
        ld_en   = 1'b1;
        ld_addr = 5'd0;
        ld_data = 16'hBEEF;
        start   = 1'b1;
        tick();
        ld_en = 1'b0;
        start = 1'b0;
        tick();
        total++;
        if (w_valid !== 1'b1 || w_data !== 16'hBEEF) begin
            bad++;
            $display("FAIL same_cycle_first: got v=%b d=%h, required 1 beef", w_valid, w_data);
        end
        fill_ramp_q();
        exp_q[0] = 16'hBEEF;
        drain_check(4'b1111, "same_cycle");
        load_word(0, 16'h0100);
    endtask

    task test_reset_mid;
        int n;
        w_ready = 1'b1;
        start_stream();
        n = 0;
        while (!(w_valid && w_data == 16'h010A) && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (n >= 100) begin
            bad++;
            $display("FAIL mid_wait: got no beat 10, required one within 100 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (w_data !== '0 || w_valid !== 1'b0 || w_last !== 1'b0 || busy !== 1'b0
            || par_err !== 1'b0 || ld_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got d=%h v=%b l=%b busy=%b p=%b e=%b, required all 0",
                     w_data, w_valid, w_last, busy, par_err, ld_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (w_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_after_release: got v=%b busy=%b, required 0 0", w_valid, busy);
        end
        fill_ramp_q();
        start_stream();
        drain_check(4'b1111, "after_reset");
    endtask

    task test_parity;
`ifdef WMEM_PARITY_EN
        dut.u_ram.mem[7][0] = ~dut.u_ram.mem[7][0];
        par_bad_idx = 7;
        fill_ramp_q();
        exp_q[7] = 16'h0106;
        start_stream();
        drain_check(4'b1011, "parity");
        par_bad_idx = -1;
        load_word(7, 16'h0107);
`else
        fill_ramp_q();
        start_stream();
        drain_check(4'b1011, "no_parity");
`endif
    endtask

    initial begin
        test_reset();
        test_stream_basic();
        test_ready_toggle();
        test_load_errors();
        test_start_in_drain();
        test_ld_start_same();
        test_reset_mid();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
